// File: rtl/egcd_pkg.sv
// Shared EGCD definitions: field widths, coefficient modulus, the empty-polynomial
// degree marker, the Bezout-update FSM state type and a modular subtract helper.
package egcd_pkg;

  localparam int unsigned Q_MOD = 4591;
  localparam int unsigned CW    = 13;
  localparam int unsigned AW    = 11;

  // Degree value that marks an empty polynomial.
  localparam logic [AW-1:0] DEG_NONE = '1;

  typedef enum logic [3:0] {
    StIdle,
    StCRd,
    StCWr,
    StMRd,
    StMEx,
    StMPipe,
    StMWr,
    StNRd,
    StNChk,
    StDone
  } bez_state_t;

  // (w - p) mod Q_MOD for w, p in [0, Q_MOD-1]. The wrap branch cannot exceed
  // Q_MOD-1, so plain CW-bit arithmetic is exact.
  function automatic logic [CW-1:0] sub_mod_q(input logic [CW-1:0] w, input logic [CW-1:0] p);
    if (w >= p) begin
      return w - p;
    end
    return w + CW'(Q_MOD) - p;
  endfunction

endpackage

// File: rtl/egcd_bezout_update_if.sv
// Bus bundle of the Bezout update stage: start/degree handshake, the A/Q/B read
// ports, the shared W read/write port and the status outputs.
interface egcd_bezout_update_if;
  import egcd_pkg::*;

  logic          start;
  logic [AW-1:0] deg_a;
  logic [AW-1:0] deg_q;
  logic [AW-1:0] deg_b;
  logic [AW-1:0] addr_a;
  logic [CW-1:0] data_a;
  logic [AW-1:0] addr_q;
  logic [CW-1:0] data_q;
  logic [AW-1:0] addr_b;
  logic [CW-1:0] data_b;
  logic [AW-1:0] addr_w;
  logic [CW-1:0] wdata_w;
  logic          we_w;
  logic [CW-1:0] rdata_w;
  logic          busy;
  logic          done;
  logic [AW-1:0] deg_w;

  // Caller plus RAM side.
  modport master (
    output start, deg_a, deg_q, deg_b, data_a, data_q, data_b, rdata_w,
    input  addr_a, addr_q, addr_b, addr_w, wdata_w, we_w, busy, done, deg_w
  );

  // Bezout update engine side.
  modport slave (
    input  start, deg_a, deg_q, deg_b, data_a, data_q, data_b, rdata_w,
    output addr_a, addr_q, addr_b, addr_w, wdata_w, we_w, busy, done, deg_w
  );

endinterface

// File: rtl/mod_q_mul.sv
// CW x CW -> CW multiply modulo Q_MOD.
// Combinational by default; with PIPE_MULT_EN defined the raw product is
// registered (when i_en is high) and reduction happens from that register.
module mod_q_mul
  import egcd_pkg::*;
(
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_en,
  input  logic [CW-1:0] i_a,
  input  logic [CW-1:0] i_b,
  output logic [CW-1:0] o_p
);

  logic [2*CW-1:0] w_prod;
  logic [2*CW-1:0] w_red;
  logic            w_unused;

  assign w_prod = {{CW{1'b0}}, i_a} * {{CW{1'b0}}, i_b};

`ifdef PIPE_MULT_EN
  logic [2*CW-1:0] r_prod;

  // Capture the raw product; reduction is done in the following cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_prod <= '0;
    end else if (i_en) begin
      r_prod <= w_prod;
    end
  end

  assign w_red    = r_prod % (2*CW)'(Q_MOD);
  assign w_unused = ^w_red[2*CW-1:CW];
`else
  assign w_red    = w_prod % (2*CW)'(Q_MOD);
  assign w_unused = ^{i_clk, i_rst_n, i_en, w_red[2*CW-1:CW]};
`endif

  assign o_p = w_red[CW-1:0];

endmodule

// File: rtl/egcd_bezout_update.sv
// EGCD Bezout coefficient update: W = (A - Q*B) mod Q_MOD, then the degree of W
// is normalised by scanning down from the top for the first non-zero term.
// Phases: copy A into W (zero-filled above deg_a), MAC Q*B out of W, normalise.
// Optional macro PIPE_MULT_EN: adds a product pipeline state per MAC term.
module egcd_bezout_update
  import egcd_pkg::*;
(
  input logic                  i_clk,
  input logic                  i_rst_n,
  egcd_bezout_update_if.slave  io_bus
);

  bez_state_t    r_state;
  logic [AW:0]   r_d;
  logic [AW-1:0] r_deg_a;
  logic [AW-1:0] r_deg_q;
  logic [AW-1:0] r_deg_b;
  logic [AW-1:0] r_k;
  logic [AW-1:0] r_i;
  logic [AW-1:0] r_j;
  logic [AW-1:0] r_e;
  logic [AW-1:0] r_addr_a;
  logic [AW-1:0] r_addr_q;
  logic [AW-1:0] r_addr_b;
  logic [AW-1:0] r_addr_w;
  logic          r_we_w;
  logic          r_busy;
  logic          r_done;
  logic [AW-1:0] r_deg_w;
  logic [CW-1:0] r_w;
  logic [CW-1:0] r_p;

  logic [AW:0]   w_qb;
  logic [AW:0]   w_d;
  logic [CW-1:0] w_p;
  logic [CW-1:0] w_wdata;
  logic          w_mul_en;

  assign w_qb     = {1'b0, io_bus.deg_q} + {1'b0, io_bus.deg_b};
  assign w_mul_en = (r_state == StMEx);

  // Working degree d = max(deg_a, deg_q + deg_b); an empty Q contributes nothing.
  always_comb begin
    w_d = {1'b0, io_bus.deg_a};
    if ((io_bus.deg_q != DEG_NONE) && (w_qb > w_d)) begin
      w_d = w_qb;
    end
  end

  mod_q_mul u_mul (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_en    (w_mul_en),
    .i_a     (io_bus.data_q),
    .i_b     (io_bus.data_b),
    .o_p     (w_p)
  );

  // W write data: A read data (or zero above deg_a) when copying, w - p when accumulating.
  always_comb begin
    w_wdata = '0;
    case (r_state)
      StCWr: begin
        if (r_k <= r_deg_a) begin
          w_wdata = io_bus.data_a;
        end
      end
      StMWr:   w_wdata = sub_mod_q(r_w, r_p);
      default: w_wdata = '0;
    endcase
  end

  // Control FSM with registered addresses, write enable and status outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= StIdle;
      r_d      <= '0;
      r_deg_a  <= '0;
      r_deg_q  <= '0;
      r_deg_b  <= '0;
      r_k      <= '0;
      r_i      <= '0;
      r_j      <= '0;
      r_e      <= '0;
      r_addr_a <= '0;
      r_addr_q <= '0;
      r_addr_b <= '0;
      r_addr_w <= '0;
      r_we_w   <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_deg_w  <= '0;
      r_w      <= '0;
      r_p      <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          r_done <= 1'b0;
          if (io_bus.start) begin
            r_deg_a  <= io_bus.deg_a;
            r_deg_q  <= io_bus.deg_q;
            r_deg_b  <= io_bus.deg_b;
            r_d      <= w_d;
            r_k      <= '0;
            r_addr_a <= '0;
            r_busy   <= 1'b1;
            r_state  <= StCRd;
          end
        end
        StCRd: begin
          r_addr_w <= r_k;
          r_we_w   <= 1'b1;
          r_state  <= StCWr;
        end
        StCWr: begin
          r_we_w <= 1'b0;
          if ({1'b0, r_k} == r_d) begin
            if (r_deg_q == DEG_NONE) begin
              r_e      <= r_d[AW-1:0];
              r_addr_w <= r_d[AW-1:0];
              r_state  <= StNRd;
            end else begin
              r_i      <= '0;
              r_j      <= '0;
              r_addr_q <= '0;
              r_addr_b <= '0;
              r_addr_w <= '0;
              r_state  <= StMRd;
            end
          end else begin
            r_k      <= r_k + 1'b1;
            r_addr_a <= r_k + 1'b1;
            r_state  <= StCRd;
          end
        end
        StMRd: begin
          r_state <= StMEx;
        end
        StMEx: begin
          r_w <= io_bus.rdata_w;
`ifdef PIPE_MULT_EN
          r_state <= StMPipe;
`else
          r_p     <= w_p;
          r_we_w  <= 1'b1;
          r_state <= StMWr;
`endif
        end
        StMPipe: begin
          r_p     <= w_p;
          r_we_w  <= 1'b1;
          r_state <= StMWr;
        end
        StMWr: begin
          r_we_w <= 1'b0;
          if (r_j == r_deg_b) begin
            if (r_i == r_deg_q) begin
              r_e      <= r_d[AW-1:0];
              r_addr_w <= r_d[AW-1:0];
              r_state  <= StNRd;
            end else begin
              r_i      <= r_i + 1'b1;
              r_j      <= '0;
              r_addr_q <= r_i + 1'b1;
              r_addr_b <= '0;
              r_addr_w <= r_i + 1'b1;
              r_state  <= StMRd;
            end
          end else begin
            r_j      <= r_j + 1'b1;
            r_addr_b <= r_j + 1'b1;
            r_addr_w <= r_i + r_j + 1'b1;
            r_state  <= StMRd;
          end
        end
        StNRd: begin
          r_state <= StNChk;
        end
        StNChk: begin
          if ((io_bus.rdata_w == '0) && (r_e != '0)) begin
            r_e      <= r_e - 1'b1;
            r_addr_w <= r_e - 1'b1;
            r_state  <= StNRd;
          end else begin
            r_deg_w <= r_e;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= StDone;
          end
        end
        StDone: begin
          r_done  <= 1'b0;
          r_state <= StIdle;
        end
        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign io_bus.addr_a  = r_addr_a;
  assign io_bus.addr_q  = r_addr_q;
  assign io_bus.addr_b  = r_addr_b;
  assign io_bus.addr_w  = r_addr_w;
  assign io_bus.wdata_w = w_wdata;
  assign io_bus.we_w    = r_we_w;
  assign io_bus.busy    = r_busy;
  assign io_bus.done    = r_done;
  assign io_bus.deg_w   = r_deg_w;

endmodule
